// File: rtl/hazard_scoreboard.sv
// Interlock and forwarding controller: shadows dest/load info for EXE, MEM and WB,
// raises the ID stall on load-use and picks the youngest forwarding source per operand.
module hazard_scoreboard #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             ds_valid,
    input  logic [4:0]       ds_rs1,
    input  logic [4:0]       ds_rs2,
    input  logic             ds_rs1_used,
    input  logic             ds_rs2_used,
    input  logic             ds_rf_we,
    input  logic [4:0]       ds_rf_waddr,
    input  logic             ds_is_load,
    input  logic             es_allow_in,
    input  logic             ms_allow_in,
    input  logic             ws_allow_in,
    input  logic             flush,
    output logic             ds_stall,
    output logic [1:0]       fwd_sel1,
    output logic [1:0]       fwd_sel2,
    output logic [CNT_W-1:0] lu_stall_cnt
);

    logic             e_v_q, e_v_d, m_v_q, m_v_d, w_v_q, w_v_d;
    logic [4:0]       e_waddr_q, e_waddr_d, m_waddr_q, m_waddr_d, w_waddr_q, w_waddr_d;
    logic             e_load_q, e_load_d, m_load_q, m_load_d, w_load_q, w_load_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic hit_e1, hit_m1, hit_w1, hit_e2, hit_m2, hit_w2;
    logic src1_live, src2_live;
    logic id_fire;

    // r0 and unused sources never match, so they can neither stall nor forward.
    always_comb begin
        src1_live = ds_rs1_used && (ds_rs1 != 5'd0);
        src2_live = ds_rs2_used && (ds_rs2 != 5'd0);

        hit_e1 = src1_live && e_v_q && (e_waddr_q == ds_rs1);
        hit_m1 = src1_live && m_v_q && (m_waddr_q == ds_rs1);
        hit_w1 = src1_live && w_v_q && (w_waddr_q == ds_rs1);
        hit_e2 = src2_live && e_v_q && (e_waddr_q == ds_rs2);
        hit_m2 = src2_live && m_v_q && (m_waddr_q == ds_rs2);
        hit_w2 = src2_live && w_v_q && (w_waddr_q == ds_rs2);

        ds_stall = ds_valid && ((hit_e1 && e_load_q) || (hit_e2 && e_load_q));
        id_fire  = ds_valid && !ds_stall && es_allow_in;

        if (hit_e1)      fwd_sel1 = 2'd1;
        else if (hit_m1) fwd_sel1 = 2'd2;
        else if (hit_w1) fwd_sel1 = 2'd3;
        else             fwd_sel1 = 2'd0;

        if (hit_e2)      fwd_sel2 = 2'd1;
        else if (hit_m2) fwd_sel2 = 2'd2;
        else if (hit_w2) fwd_sel2 = 2'd3;
        else             fwd_sel2 = 2'd0;
    end

    always_comb begin
        e_v_d     = e_v_q;
        e_waddr_d = e_waddr_q;
        e_load_d  = e_load_q;
        m_v_d     = m_v_q;
        m_waddr_d = m_waddr_q;
        m_load_d  = m_load_q;
        w_v_d     = w_v_q;
        w_waddr_d = w_waddr_q;
        w_load_d  = w_load_q;

        if (es_allow_in) begin
            if (id_fire) begin
                e_v_d     = ds_rf_we && (ds_rf_waddr != 5'd0);
                e_waddr_d = ds_rf_waddr;
                e_load_d  = ds_is_load;
            end else begin
                e_v_d = 1'b0;
            end
        end else if (ms_allow_in) begin
            e_v_d = 1'b0;
        end

        if (ms_allow_in) begin
            m_v_d     = e_v_q;
            m_waddr_d = e_waddr_q;
            m_load_d  = e_load_q;
        end

        if (ws_allow_in) begin
            w_v_d     = m_v_q;
            w_waddr_d = m_waddr_q;
            w_load_d  = m_load_q;
        end

        // Flush overrides any simultaneous issue or advance.
        if (flush) begin
            e_v_d = 1'b0;
            m_v_d = 1'b0;
            w_v_d = 1'b0;
        end

        cnt_d = cnt_q;
        if (ds_stall && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            e_v_q     <= 1'b0;
            e_waddr_q <= 5'd0;
            e_load_q  <= 1'b0;
            m_v_q     <= 1'b0;
            m_waddr_q <= 5'd0;
            m_load_q  <= 1'b0;
            w_v_q     <= 1'b0;
            w_waddr_q <= 5'd0;
            w_load_q  <= 1'b0;
            cnt_q     <= '0;
        end else begin
            e_v_q     <= e_v_d;
            e_waddr_q <= e_waddr_d;
            e_load_q  <= e_load_d;
            m_v_q     <= m_v_d;
            m_waddr_q <= m_waddr_d;
            m_load_q  <= m_load_d;
            w_v_q     <= w_v_d;
            w_waddr_q <= w_waddr_d;
            w_load_q  <= w_load_d;
            cnt_q     <= cnt_d;
        end
    end

    assign lu_stall_cnt = cnt_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard (CNT_W=4): expected outputs are queued per cycle
// and popped for comparison at the falling edge.
module tb_hazard_scoreboard;

    localparam int unsigned CNT_W = 4;

    logic             clk;
    logic             resetn;
    logic             ds_valid;
    logic [4:0]       ds_rs1, ds_rs2;
    logic             ds_rs1_used, ds_rs2_used;
    logic             ds_rf_we;
    logic [4:0]       ds_rf_waddr;
    logic             ds_is_load;
    logic             es_allow_in, ms_allow_in, ws_allow_in;
    logic             flush;
    logic             ds_stall;
    logic [1:0]       fwd_sel1, fwd_sel2;
    logic [CNT_W-1:0] lu_stall_cnt;

    typedef struct packed {
        logic             stall;
        logic [1:0]       s1;
        logic [1:0]       s2;
        logic [CNT_W-1:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    int   n_assert = 0;
    int   n_fail   = 0;
    int   exp_cnt  = 0;

    hazard_scoreboard #(.CNT_W(CNT_W)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .ds_valid     (ds_valid),
        .ds_rs1       (ds_rs1),
        .ds_rs2       (ds_rs2),
        .ds_rs1_used  (ds_rs1_used),
        .ds_rs2_used  (ds_rs2_used),
        .ds_rf_we     (ds_rf_we),
        .ds_rf_waddr  (ds_rf_waddr),
        .ds_is_load   (ds_is_load),
        .es_allow_in  (es_allow_in),
        .ms_allow_in  (ms_allow_in),
        .ws_allow_in  (ws_allow_in),
        .flush        (flush),
        .ds_stall     (ds_stall),
        .fwd_sel1     (fwd_sel1),
        .fwd_sel2     (fwd_sel2),
        .lu_stall_cnt (lu_stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic id(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic u1, input logic u2, input logic we,
                      input logic [4:0] wa, input logic ld);
        ds_valid    = v;
        ds_rs1      = rs1;
        ds_rs2      = rs2;
        ds_rs1_used = u1;
        ds_rs2_used = u2;
        ds_rf_we    = we;
        ds_rf_waddr = wa;
        ds_is_load  = ld;
    endtask

    task automatic idle();
        id(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
    endtask

    task automatic push(input logic st, input logic [1:0] s1, input logic [1:0] s2);
        exp_t e;
        e.stall = st;
        e.s1    = s1;
        e.s2    = s2;
        e.cnt   = exp_cnt[CNT_W-1:0];
        exp_q.push_back(e);
    endtask

    task automatic cmp(input string tag);
        exp_t e;
        if (exp_q.size() == 0) begin
            n_assert++;
            n_fail++;
            $error("FAIL %s: scoreboard empty, observed nothing to match", tag);
            return;
        end
        e = exp_q.pop_front();
        n_assert++;
        assert (ds_stall === e.stall) else begin
            n_fail++;
            $error("FAIL %s.stall: observed %b expected %b", tag, ds_stall, e.stall);
        end
        n_assert++;
        assert (fwd_sel1 === e.s1) else begin
            n_fail++;
            $error("FAIL %s.sel1: observed %0d expected %0d", tag, fwd_sel1, e.s1);
        end
        n_assert++;
        assert (fwd_sel2 === e.s2) else begin
            n_fail++;
            $error("FAIL %s.sel2: observed %0d expected %0d", tag, fwd_sel2, e.s2);
        end
        n_assert++;
        assert (lu_stall_cnt === e.cnt) else begin
            n_fail++;
            $error("FAIL %s.cnt: observed %0d expected %0d", tag, lu_stall_cnt, e.cnt);
        end
    endtask

    // One ID cycle: queue expectation, compare mid-cycle, then step past the next edge.
    task automatic cyc(input string tag, input logic st, input logic [1:0] s1,
                       input logic [1:0] s2);
        push(st, s1, s2);
        @(negedge clk);
        cmp(tag);
        if (st && exp_cnt < 15) exp_cnt++;
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        idle();
        for (int i = 0; i < 3; i++) cyc("drain", 1'b0, 2'd0, 2'd0);
    endtask

    initial begin
        resetn      = 1'b0;
        flush       = 1'b0;
        es_allow_in = 1'b1;
        ms_allow_in = 1'b1;
        ws_allow_in = 1'b1;
        idle();
        #2;
        push(1'b0, 2'd0, 2'd0);
        cmp("reset");
        #6 resetn = 1'b1;
        @(posedge clk);
        #1;

        // add r5,r1,r2 ; add r6,r5,r3 with 0, 1 and 2 gaps
        id(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 5'd5, 1'b0);
        cyc("b2b_prod", 1'b0, 2'd0, 2'd0);
        id(1'b1, 5'd5, 5'd3, 1'b1, 1'b1, 1'b1, 5'd6, 1'b0);
        cyc("b2b_exe", 1'b0, 2'd1, 2'd0);
        drain();
        id(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 5'd5, 1'b0);
        cyc("gap1_prod", 1'b0, 2'd0, 2'd0);
        idle();
        cyc("gap1_nop", 1'b0, 2'd0, 2'd0);
        id(1'b1, 5'd5, 5'd3, 1'b1, 1'b1, 1'b1, 5'd6, 1'b0);
        cyc("gap1_mem", 1'b0, 2'd2, 2'd0);
        drain();
        id(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 5'd5, 1'b0);
        cyc("gap2_prod", 1'b0, 2'd0, 2'd0);
        idle();
        cyc("gap2_nop0", 1'b0, 2'd0, 2'd0);
        cyc("gap2_nop1", 1'b0, 2'd0, 2'd0);
        id(1'b1, 5'd5, 5'd3, 1'b1, 1'b1, 1'b1, 5'd6, 1'b0);
        cyc("gap2_wb", 1'b0, 2'd3, 2'd0);
        drain();

        // ld.w r4,0(r2) ; add.w r7,r4,r4
        id(1'b1, 5'd2, 5'd0, 1'b1, 1'b0, 1'b1, 5'd4, 1'b1);
        cyc("lu_load", 1'b0, 2'd0, 2'd0);
        id(1'b1, 5'd4, 5'd4, 1'b1, 1'b1, 1'b1, 5'd7, 1'b0);
        cyc("lu_stall", 1'b1, 2'd1, 2'd1);
        cyc("lu_release", 1'b0, 2'd2, 2'd2);
        drain();

        // r0 destination and unused operand
        id(1'b1, 5'd2, 5'd0, 1'b1, 1'b0, 1'b1, 5'd0, 1'b1);
        cyc("r0_load", 1'b0, 2'd0, 2'd0);
        id(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 5'd1, 1'b0);
        cyc("r0_use", 1'b0, 2'd0, 2'd0);
        drain();
        id(1'b1, 5'd2, 5'd0, 1'b1, 1'b0, 1'b1, 5'd8, 1'b1);
        cyc("st_load", 1'b0, 2'd0, 2'd0);
        id(1'b1, 5'd3, 5'd8, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0);
        cyc("st_unused", 1'b0, 2'd0, 2'd0);
        drain();

        // r9 written by W, M and E at once
        id(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 5'd9, 1'b0);
        cyc("pri_w0", 1'b0, 2'd0, 2'd0);
        cyc("pri_w1", 1'b0, 2'd0, 2'd0);
        cyc("pri_w2", 1'b0, 2'd0, 2'd0);
        id(1'b1, 5'd9, 5'd9, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0);
        cyc("pri_exe", 1'b0, 2'd1, 2'd1);
        cyc("pri_mem", 1'b0, 2'd2, 2'd2);
        drain();

        // Back-pressure: E=r13, M=r11, W=r10 frozen for three cycles
        id(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 5'd10, 1'b0);
        cyc("bp_w10", 1'b0, 2'd0, 2'd0);
        id(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 5'd11, 1'b0);
        cyc("bp_w11", 1'b0, 2'd0, 2'd0);
        id(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 5'd13, 1'b0);
        cyc("bp_w13", 1'b0, 2'd0, 2'd0);
        id(1'b1, 5'd10, 5'd11, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0);
        es_allow_in = 1'b0;
        ms_allow_in = 1'b0;
        ws_allow_in = 1'b0;
        for (int i = 0; i < 3; i++) cyc("bp_hold", 1'b0, 2'd3, 2'd2);
        es_allow_in = 1'b1;
        ms_allow_in = 1'b1;
        ws_allow_in = 1'b1;
        cyc("bp_resume", 1'b0, 2'd3, 2'd2);
        // E=reader, M=r13, W=r11; issue r12 with flush in the same cycle
        id(1'b1, 5'd13, 5'd11, 1'b1, 1'b1, 1'b1, 5'd12, 1'b0);
        flush = 1'b1;
        cyc("flush_fire", 1'b0, 2'd2, 2'd3);
        flush = 1'b0;
        id(1'b1, 5'd12, 5'd13, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0);
        cyc("flush_after", 1'b0, 2'd0, 2'd0);
        drain();

        // Load pinned in E by back-pressure: long stall saturates the counter
        id(1'b1, 5'd2, 5'd0, 1'b1, 1'b0, 1'b1, 5'd4, 1'b1);
        cyc("sat_load", 1'b0, 2'd0, 2'd0);
        es_allow_in = 1'b0;
        ms_allow_in = 1'b0;
        id(1'b1, 5'd4, 5'd4, 1'b1, 1'b1, 1'b1, 5'd7, 1'b0);
        for (int i = 0; i < 20; i++) cyc("sat_stall", 1'b1, 2'd1, 2'd1);
        cyc("sat_full", 1'b1, 2'd1, 2'd1);

        // Asynchronous reset between edges clears counter and slots immediately
        #2 resetn = 1'b0;
        #1;
        exp_cnt = 0;
        push(1'b0, 2'd0, 2'd0);
        cmp("async_reset");
        #3 resetn = 1'b1;
        es_allow_in = 1'b1;
        ms_allow_in = 1'b1;
        @(posedge clk);
        #1;
        cyc("post_reset", 1'b0, 2'd0, 2'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: observed no finish, expected finish before 100000");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Pipeline interlock and forwarding controller for the five-stage LA32R core. It tracks the destination register and load flag of every in-flight instruction in EXE, MEM and WB, using three shadow slots that advance with the stage handshakes. It drives the ID-stage stall on load-use hazards and the per-operand forwarding selects. It also keeps a saturating count of load-use stall cycles.

## Interface
Parameters:
- CNT_W, 16, width of the load-use stall counter.

Ports:
- clk  in  1  core clock.
- resetn  in  1  asynchronous, active-low reset.
- ds_valid  in  1  ID holds a valid instruction.
- ds_rs1, ds_rs2  in  5 each  ID source register numbers.
- ds_rs1_used, ds_rs2_used  in  1 each  the source is actually read (rs2 is rd for st.w/beq/bne/bge).
- ds_rf_we  in  1  ID instruction writes the register file.
- ds_rf_waddr  in  5  ID destination (already resolved to r1 for bl).
- ds_is_load  in  1  ID instruction is ld.w.
- es_allow_in, ms_allow_in, ws_allow_in  in  1 each  stage accepts a new instruction this cycle.
- flush  in  1  kill all in-flight tracking (exception/ertn).
- ds_stall  out  1  hold ID; feeds ID stall.
- fwd_sel1, fwd_sel2  out  2 each  operand source: 0 RF, 1 EXE, 2 MEM, 3 WB.
- lu_stall_cnt  out  CNT_W  saturating count of load-use stall cycles.

## Operation
- Slots E, M and W each hold {v, waddr[4:0], load}. v is set only if rf_we=1 and waddr≠0, so r0 never creates a hazard.
- id_fire = ds_valid & ~ds_stall & es_allow_in.
- Slot E:
  - If es_allow_in: E ← id_fire ? {ds_rf_we&&ds_rf_waddr≠0, ds_rf_waddr, ds_is_load} : invalid.
  - Else if ms_allow_in: E ← invalid, because EXE drained.
  - Else hold.
- Slot M: M ← E when ms_allow_in, otherwise hold.
- Slot W: W ← M when ws_allow_in, otherwise hold.
- Match for source s (s≠0, used): hitX = X.v & X.waddr==s.
- fwd_sel priority is the youngest writer: hitE→1, else hitM→2, else hitW→3, else 0. fwd_sel is 0 when the source is unused or is r0.
- ds_stall = ds_valid & ((rs1 used & hitE1 & E.load) | (rs2 used & hitE2 & E.load)). Loads in M or W are forwardable, so they do not stall.
- lu_stall_cnt increments by 1 each cycle ds_stall=1, and saturates at all-ones.
- flush: E, M and W all become invalid on the next edge. flush takes priority over every simultaneous advance or issue. The counter is not cleared by flush.

## Timing
- Reset values (asynchronous, resetn=0): all slots invalid, lu_stall_cnt=0. This gives ds_stall=0 and fwd_sel1=fwd_sel2=0.
- ds_stall and fwd_sel are combinational from the current slots and the ID inputs, so they are valid in the same cycle as the ID inputs.
- Slots update on the rising edge of clk. An issued instruction appears in E one cycle after id_fire, in M one cycle after that (given the allow signals), and in W one cycle later again.
- Load-use costs exactly one stall cycle:
  - Cycle n: the load is in E, so ID stalls and E takes a bubble.
  - Cycle n+1: the load is in M, so fwd_sel=2 and the stall drops.
- While stalled with es_allow_in=1, E receives a bubble, never a duplicate of the ID instruction.
- Reset deasserted mid-operation: the next edge starts from all-invalid. No stale hazards are carried over.

## Test plan
- Back-to-back dependence: add.w r5,r1,r2 then add.w r6,r5,r3. Expect ds_stall=0 and fwd_sel1=1 in the second instruction's ID cycle. With one NOP in between, expect fwd_sel1=2; with two NOPs, fwd_sel1=3.
- Load-use: ld.w r4,0(r2) then add.w r7,r4,r4. Expect ds_stall=1 for exactly one cycle, with fwd_sel1=fwd_sel2=1 in that cycle. The next cycle shows ds_stall=0 and fwd_sel1=fwd_sel2=2, and lu_stall_cnt goes 0→1.
- r0 and unused operands: ld.w r0 then add.w r1,r0,r0 gives no stall and fwd_sel=0. st.w with rs2_used=0 and rs2 matching a pending load gives no stall.
- Priority: writes to r9 in W, M and E simultaneously, then a reader of r9. Expect fwd_sel=1. After E's instruction is a bubble, expect fwd_sel=2.
- Back-pressure and flush: hold ms_allow_in=0 for 3 cycles and check M and W hold with outputs stable. Assert flush in the same cycle as id_fire and check all slots are invalid on the next cycle.
- Counter saturation with CNT_W=4: force 20 consecutive stall cycles. Expect lu_stall_cnt=15. Assert resetn=0 asynchronously mid-clock and expect the counter at 0 immediately.
